// File: rtl/lgn_feeder_pkg.sv
// Shared types and constants for the LGN feeder: FSM state encoding,
// seven-segment digit patterns and default frame/settle sizes.
package lgn_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESULT = 2'd3
  } lgn_state_t;

  localparam int BYTES_DEF  = 98;
  localparam int SETTLE_DEF = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7C;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h67;

  localparam logic [3:0] DIGIT_BAD    = 4'hF;
  localparam logic [7:0] TIMEOUT_IDLE = 8'd255;

endpackage

// File: rtl/lgn_feeder_if.sv
// Host/classifier signal bundle for lgn_feeder; slave = feeder, master = host side.
interface lgn_feeder_if;
  // Both in_* and res_* are valid/ready pairs: a transfer happens on a rising
  // clock edge where valid && ready are both 1; the sender holds data stable
  // while valid=1 and ready=0, and ready never depends combinationally on valid.
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  lgn_data;
  logic        lgn_we;
  logic [15:0] lgn_out;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_digit;
  logic [7:0]  res_score;
  logic        res_error;
  logic        timeout;

  modport slave (
    input  in_valid, in_data, lgn_out, res_ready,
    output in_ready, lgn_data, lgn_we, res_valid, res_digit, res_score,
           res_error, timeout
  );

  modport master (
    output in_valid, in_data, lgn_out, res_ready,
    input  in_ready, lgn_data, lgn_we, res_valid, res_digit, res_score,
           res_error, timeout
  );
endinterface

// File: rtl/lgn_feeder_seg7_decode.sv
// Combinational seven-segment pattern to digit decoder; unknown patterns
// give digit F with valid=0.
module seg7_decode
  import lgn_feeder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = DIGIT_BAD;
    valid = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/lgn_feeder.sv
// Streams a packed image frame byte-by-byte into the classifier, waits for it
// to settle and returns the decoded digit. LGN_FEEDER_TIMEOUT_EN adds a LOAD-stall abort.
module lgn_feeder
  import lgn_feeder_pkg::*;
#(
  parameter int BYTES  = BYTES_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  lgn_feeder_if.slave   bus,
  output lgn_state_t    dbg_state
);

  localparam int CW = $clog2(BYTES + 1);

  lgn_state_t    state, state_nx;
  logic [CW-1:0] count;
  logic [7:0]    scnt;
  logic          ready_q, ready_nx;
  logic          accept, last_byte, settle_done, res_take, abort, sample_en;
  logic [7:0]    data_q;
  logic          we_q;
  logic          rv_q, err_q;
  logic [3:0]    digit_q;
  logic [7:0]    score_q;
  logic [3:0]    dec_digit;
  logic          dec_valid;

  assign accept      = bus.in_valid && ready_q;
  assign last_byte   = (count == CW'(BYTES - 1));
  assign settle_done = (scnt == 8'(SETTLE));
  assign res_take    = rv_q && bus.res_ready;

  seg7_decode u_dec (
    .pattern (bus.lgn_out[6:0]),
    .digit   (dec_digit),
    .valid   (dec_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = last_byte ? ST_SETTLE : ST_LOAD;
      ST_LOAD: begin
        if (accept && last_byte) state_nx = ST_SETTLE;
        else if (abort)          state_nx = ST_IDLE;
      end
      ST_SETTLE: if (settle_done) state_nx = ST_RESULT;
      ST_RESULT: if (res_take)    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // in_ready is registered from the next state so it is 0 through reset and
  // only rises on the clock after a result is taken.
  always_comb begin
    ready_nx  = (state_nx == ST_IDLE) || (state_nx == ST_LOAD);
    sample_en = (state == ST_SETTLE) && settle_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      count   <= '0;
      scnt    <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      ready_q <= ready_nx;
      we_q    <= accept;
      if (accept) data_q <= bus.in_data;
      if (accept)     count <= last_byte ? '0 : count + CW'(1);
      else if (abort) count <= '0;
      // scnt runs from the cycle after the last write pulse; it reads 0 during that pulse.
      if (state == ST_SETTLE && !settle_done) scnt <= scnt + 8'd1;
      else                                    scnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q    <= 1'b0;
      digit_q <= '0;
      score_q <= '0;
      err_q   <= 1'b0;
    end else if (sample_en) begin
      rv_q    <= 1'b1;
      digit_q <= dec_digit;
      score_q <= bus.lgn_out[15:8];
      err_q   <= !dec_valid || !bus.lgn_out[7];
    end else if (res_take) begin
      rv_q    <= 1'b0;
    end
  end

`ifdef LGN_FEEDER_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       timeout_q;

  // Fires on the 255th consecutive LOAD cycle with no accepted byte.
  assign abort = (state == ST_LOAD) && !accept && (idle_cnt == TIMEOUT_IDLE - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (state != ST_LOAD || accept) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + 8'd1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign abort       = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.in_ready  = ready_q;
  assign bus.lgn_data  = data_q;
  assign bus.lgn_we    = we_q;
  assign bus.res_valid = rv_q;
  assign bus.res_digit = digit_q;
  assign bus.res_score = score_q;
  assign bus.res_error = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_lgn_feeder.sv
// Self-checking bench for lgn_feeder: randomized frames against a frame-level
// reference model (byte stream queue, sampled-output history, digit table).
module tb_lgn_feeder;
  import lgn_feeder_pkg::*;

  localparam int BYTES  = 98;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  lgn_state_t dbg_state;

  lgn_feeder_if bus();

  lgn_feeder #(.BYTES(BYTES), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] hist[int];
  logic [6:0]  pats[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_acc = 0, results = 0;
  int we_total = 0, run = 0, max_run = 0, to_count = 0, to_cyc = 0;
  logic       rv_prev = 1'b0;
  logic [3:0] exp_digit = '0;
  logic [7:0] exp_score = '0;
  logic       exp_err = 1'b0;
  logic        lo_fixed_en = 1'b0;
  logic [15:0] lo_fixed = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_decode(input logic [15:0] lo, output logic [3:0] d,
                                       output logic e);
    d = 4'hF;
    e = 1'b1;
    for (int i = 0; i < 10; i++)
      if (pats[i] == lo[6:0]) begin
        d = 4'(i);
        e = 1'b0;
      end
    if (!lo[7]) e = 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_lo();
    logic [6:0] p;
    if (lo_fixed_en) begin
      bus.lgn_out = lo_fixed;
    end else begin
      if ($urandom_range(9) < 7) p = pats[$urandom_range(9)];
      else                       p = 7'($urandom);
      bus.lgn_out = {8'($urandom), ($urandom_range(9) != 0), p};
    end
  endtask

  // One clock: record what the edge will see, advance, then monitor outputs at negedge.
  task automatic step();
    logic acc, hs;
    logic [15:0] lo;
    int idx;
    acc = bus.in_valid && bus.in_ready;
    hs  = bus.res_valid && bus.res_ready;
    if (acc) begin
      exp_q.push_back(bus.in_data);
      last_acc = cyc;
    end
    hist[cyc] = bus.lgn_out;
    if (hs) check("ready_low_at_take", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.lgn_we) begin
      we_total++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) check("we_spurious", 32'(bus.lgn_we), 32'(0));
      else                   check("we_data", 32'(bus.lgn_data), 32'(exp_q.pop_front()));
    end else begin
      run = 0;
    end
    if (hs) begin
      check("ready_after_take", 32'(bus.in_ready), 32'(1));
      check("rv_after_take", 32'(bus.res_valid), 32'(0));
    end
    if (bus.res_valid && !rv_prev) begin
      results++;
      check("res_latency", 32'(cyc - last_acc), 32'(SETTLE + 2));
      idx = last_acc + SETTLE + 1;
      lo = hist.exists(idx) ? hist[idx] : 16'h0;
      model_decode(lo, exp_digit, exp_err);
      exp_score = lo[15:8];
    end
    if (bus.res_valid) begin
      check("res_digit", 32'(bus.res_digit), 32'(exp_digit));
      check("res_score", 32'(bus.res_score), 32'(exp_score));
      check("res_error", 32'(bus.res_error), 32'(exp_err));
      check("we_in_result", 32'(bus.lgn_we), 32'(0));
    end
    if (bus.timeout) begin
      to_count++;
      to_cyc = cyc;
    end
    rv_prev = bus.res_valid;
  endtask

  task automatic send_frame(input int first, input bit seq, input int gap_pct, input int n);
    int sent = 0, guard = 0;
    while (sent < n && guard < 5000) begin
      if ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = seq ? 8'(first + sent) : 8'($urandom);
      end
      drive_lo();
      if (bus.in_valid && bus.in_ready) sent++;
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    check("send_bound", 32'(sent), 32'(n));
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!bus.res_valid && g < 100) begin
      drive_lo();
      step();
      g++;
    end
    check("valid_bound", 32'(bus.res_valid), 32'(1));
  endtask

  task automatic wait_result(input int ready_pct);
    int g = 0;
    logic done = 1'b0;
    while (!done && g < 2000) begin
      drive_lo();
      bus.res_ready = ($urandom_range(99) < ready_pct);
      if (bus.res_valid && bus.res_ready) done = 1'b1;
      step();
      g++;
    end
    bus.res_ready = 1'b0;
    check("result_bound", 32'(done), 32'(1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int r0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    bus.lgn_out   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(0));
    check("rst_lgn_we", 32'(bus.lgn_we), 32'(0));
    check("rst_lgn_data", 32'(bus.lgn_data), 32'(0));
    check("rst_res_valid", 32'(bus.res_valid), 32'(0));
    check("rst_res_digit", 32'(bus.res_digit), 32'(0));
    check("rst_res_score", 32'(bus.res_score), 32'(0));
    check("rst_res_error", 32'(bus.res_error), 32'(0));
    check("rst_timeout", 32'(bus.timeout), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    #1 check("ready_before_clock", 32'(bus.in_ready), 32'(0));
    step();
    check("ready_after_release", 32'(bus.in_ready), 32'(1));

    // Back-to-back 00..61 frame, score/digit A3E7 -> 9
    lo_fixed_en = 1'b1;
    lo_fixed    = 16'hA3E7;
    we_total = 0; max_run = 0; r0 = results;
    send_frame(0, 1, 0, BYTES);
    wait_valid();
    check("d9_digit", 32'(bus.res_digit), 32'(9));
    check("d9_score", 32'(bus.res_score), 32'(8'hA3));
    check("d9_error", 32'(bus.res_error), 32'(0));
    wait_result(50);
    check("b2b_we_total", 32'(we_total), 32'(BYTES));
    check("b2b_we_run", 32'(max_run), 32'(BYTES));
    check("b2b_results", 32'(results - r0), 32'(1));

    // Undecodable pattern, then held result with in_valid=1
    lo_fixed = 16'h5A00;
    send_frame(0, 0, 20, BYTES);
    wait_valid();
    check("bad_digit", 32'(bus.res_digit), 32'(4'hF));
    check("bad_error", 32'(bus.res_error), 32'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_no_accept", 32'(bus.in_ready), 32'(0));
      check("hold_valid", 32'(bus.res_valid), 32'(1));
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    step();

    // Valid pattern 3F but write-enable bit low
    lo_fixed = 16'h1C3F;
    send_frame(0, 0, 20, BYTES);
    wait_valid();
    check("we0_digit", 32'(bus.res_digit), 32'(0));
    check("we0_error", 32'(bus.res_error), 32'(1));
    wait_result(30);

    // Randomized frames: gappy input, per-cycle random classifier output
    lo_fixed_en = 1'b0;
    for (int f = 0; f < 4; f++) begin
      r0 = results;
      send_frame(0, 0, 30, BYTES);
      wait_result(40);
      check("rand_results", 32'(results - r0), 32'(1));
    end

    // Reset mid-frame
    send_frame(8'h40, 1, 0, 50);
    rst = 1'b1;
    #1;
    check("midrst_we", 32'(bus.lgn_we), 32'(0));
    check("midrst_ready", 32'(bus.in_ready), 32'(0));
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    rv_prev = 1'b0;
    step();
    r0 = results;
    send_frame(0, 0, 10, BYTES);
    wait_result(60);
    repeat (20) step();
    check("midrst_one_result", 32'(results - r0), 32'(1));

`ifdef LGN_FEEDER_TIMEOUT_EN
    // Stalled frame aborts after 255 idle cycles
    to_count = 0;
    r0 = results;
    send_frame(0, 0, 0, 10);
    repeat (300) begin
      drive_lo();
      step();
    end
    check("to_pulses", 32'(to_count), 32'(1));
    check("to_latency", 32'(to_cyc - last_acc), 32'(256));
    check("to_state", 32'(dbg_state), 32'(ST_IDLE));
    check("to_no_result", 32'(results - r0), 32'(0));
    r0 = results;
    send_frame(0, 0, 10, BYTES);
    wait_result(60);
    check("to_fresh_result", 32'(results - r0), 32'(1));
`else
    // Without the abort the feeder waits in LOAD indefinitely
    to_count = 0;
    r0 = results;
    send_frame(0, 0, 0, 10);
    repeat (300) begin
      drive_lo();
      step();
    end
    check("nto_pulses", 32'(to_count), 32'(0));
    check("nto_state", 32'(dbg_state), 32'(ST_LOAD));
    send_frame(0, 0, 10, BYTES - 10);
    wait_result(60);
    check("nto_result", 32'(results - r0), 32'(1));
`endif

    repeat (5) step();
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lgn_feeder.md
LGN_FEEDER -- requirements
Module: lgn_feeder

Interface
REQ-001 SHALL have parameter BYTES, default 98, meaning image bytes per frame (28*28/8).
REQ-002 SHALL have parameter SETTLE, default 4, meaning idle cycles after the last write before the classifier output is sampled (range 1..255).
REQ-003 SHALL have one clock and asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  host pixel byte valid.
REQ-006 SHALL have port in_ready  output  1  feeder accepts a byte this cycle.
REQ-007 SHALL have port in_data  input  8  packed pixel byte; the first byte of a frame is the MSB byte of the image.
REQ-008 SHALL have port lgn_data  output  8  byte driven to the classifier byte input.
REQ-009 SHALL have port lgn_we  output  1  classifier shift-write enable.
REQ-010 SHALL have port lgn_out  input  16  classifier output: [6:0] seven-segment digit, [7] ~write_enable, [15:8] top score bits.
REQ-011 SHALL have port res_valid  output  1  result available.
REQ-012 SHALL have port res_ready  input  1  host consumes the result.
REQ-013 SHALL have port res_digit  output  4  decoded class 0..9, or 4'hF when undecodable.
REQ-014 SHALL have port res_score  output  8  lgn_out[15:8] as sampled.
REQ-015 SHALL have port res_error  output  1  sampled pattern invalid, or lgn_out[7]==0 at the sample point.
REQ-016 SHALL have port timeout  output  1  one-cycle frame-abort pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SETTLE, RESULT.
REQ-018 SHALL assert in_ready=1 only in IDLE and LOAD; a byte is accepted when in_valid&&in_ready.
REQ-019 SHALL, in IDLE on first acceptance, go to LOAD with byte count 1; count increments per accepted byte.
REQ-020 SHALL register each accepted byte into lgn_data and assert lgn_we for exactly the following cycle, one pulse per byte, with no gaps inserted.
REQ-021 SHALL, on acceptance of byte BYTES, go to SETTLE, deassert in_ready, and clear the count.
REQ-022 SHALL count SETTLE cycles starting the cycle after the last lgn_we pulse, then sample lgn_out and enter RESULT; res_valid rises exactly SETTLE+2 cycles after the last accepting cycle.
REQ-023 SHALL decode lgn_out[6:0]: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7C->6, 07->7, 7F->8, 67->9; any other pattern gives res_digit=F and res_error=1.
REQ-024 SHALL hold res_* stable while res_valid=1 && res_ready=0.
REQ-025 SHALL, on res_valid&&res_ready, return to IDLE; in_ready rises the next cycle, never in the same cycle.
REQ-026 SHALL ignore in_valid while in_ready=0, with no byte lost or duplicated.
REQ-027 SHALL keep lgn_we=0 in SETTLE and RESULT.

Reset
REQ-028 SHALL, on rst, immediately set state IDLE, count 0, lgn_we 0, lgn_data 00, in_ready 0 (1 from the first clock after release), res_valid 0, res_digit 0, res_score 00, res_error 0, timeout 0.
REQ-029 SHALL discard a partial frame or a pending result on reset mid-operation.

Configuration
REQ-030 SHALL, with LGN_FEEDER_TIMEOUT_EN defined, abort a frame in LOAD after 255 consecutive cycles without an accepted byte: pulse timeout for 1 cycle, clear the count, go to IDLE, produce no result.
REQ-031 SHALL, without LGN_FEEDER_TIMEOUT_EN, tie timeout to 0 and wait in LOAD indefinitely.

Structure
REQ-032 SHALL place the state enum, the ten seven-segment pattern constants, and the default BYTES/SETTLE constants in shared package lgn_feeder_pkg.
REQ-033 SHALL instantiate one combinational sub-module, seg7_decode (7-bit pattern in; 4-bit digit and valid out).

Verification
REQ-034 Bench SHALL check: 98 back-to-back bytes 00..61 -> 98 consecutive lgn_we pulses carrying 00..61 in order; res_valid rises 6 cycles after the last accept (SETTLE=4).
REQ-035 Bench SHALL check: lgn_out=16'hA3E7 at the sample point -> res_digit=9, res_score=A3, res_error=0.
REQ-036 Bench SHALL check: lgn_out[6:0]=7'h00 -> res_digit=F, res_error=1; lgn_out[7]=0 with pattern 3F -> res_digit=0, res_error=1.
REQ-037 Bench SHALL check: res_ready held 0 for 10 cycles with in_valid=1 -> res_* stable, no bytes accepted; res_ready=1 -> in_ready=1 the next cycle.
REQ-038 Bench SHALL check: rst pulsed after 50 bytes -> lgn_we=0 immediately; a fresh 98-byte frame yields exactly one result.
REQ-039 Bench SHALL check, with LGN_FEEDER_TIMEOUT_EN: 10 bytes followed by 255 idle cycles -> one timeout pulse, state IDLE, res_valid never asserted.
